// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the AES-128 key-generation datapath: loads the cipher key, then runs NUM_ROUNDS
// S-box-arbitrated expansions. Optional macro ROUND_KEY_STORE_EN adds an 11-entry round-key store.
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int SBOX_LAT   = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start_i,
  input  logic         abort_i,
  output logic         busy_o,
  output logic         kg_en_o,
  output logic         kg_next_rnd_o,
  output logic         kg_gen_key_o,
  output logic [7:0]   kg_rcon_o,
  output logic         sbox_req_o,
  input  logic         sbox_gnt_i,
  output logic         rk_valid_o,
  output logic [3:0]   rk_idx_o,
`ifdef ROUND_KEY_STORE_EN
  input  logic [127:0] rk_i,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_key_o,
`endif
  output logic         done_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // LOAD  | key generator loads the cipher key
  // REQ   | requesting the shared S-box
  // SUB   | S-box granted, waiting out its latency
  // EXP   | key generator expands one round using the current rcon
  // DONE  | final round key valid, one-cycle done pulse
  typedef enum logic [2:0] {IDLE, LOAD, REQ, SUB, EXP, DONE} state_t;

  localparam int LW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
  localparam logic [3:0]    NR4      = 4'(NUM_ROUNDS);
  localparam logic [LW-1:0] LAT_LOAD = LW'(SBOX_LAT - 1);

  state_t        state, state_nxt;
  logic [3:0]    round;
  logic [LW-1:0] lat_cnt;
  logic [7:0]    rcon;
  logic          aborting;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  assign aborting = abort_i && (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = LOAD;
      LOAD:    state_nxt = REQ;
      REQ:     if (sbox_gnt_i) state_nxt = SUB;
      SUB:     if (lat_cnt == '0) state_nxt = EXP;
      EXP:     state_nxt = (round == NR4) ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (aborting) state_nxt = IDLE;
  end

  // Moore decode only, so no input reaches an output combinationally
  assign busy_o        = (state != IDLE);
  assign kg_en_o       = (state == LOAD) || (state == EXP);
  assign kg_next_rnd_o = (state == EXP);
  assign kg_gen_key_o  = (state == EXP);
  assign sbox_req_o    = (state == REQ) || (state == SUB);
  assign done_o        = (state == DONE);
  assign kg_rcon_o     = rcon;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      round      <= 4'd0;
      lat_cnt    <= '0;
      rcon       <= 8'h01;
      rk_valid_o <= 1'b0;
      rk_idx_o   <= 4'd0;
    end else begin
      state      <= state_nxt;
      rk_valid_o <= kg_en_o;
      if (kg_en_o) rk_idx_o <= (state == LOAD) ? 4'd0 : round;
      if (aborting) begin
        rcon <= 8'h01;
      end else begin
        case (state)
          LOAD: round <= 4'd1;
          REQ:  if (sbox_gnt_i) lat_cnt <= LAT_LOAD;
          SUB:  if (lat_cnt != '0) lat_cnt <= lat_cnt - LW'(1);
          EXP: begin
            rcon <= xtime(rcon);
            if (round != NR4) round <= round + 4'd1;
          end
          DONE: rcon <= 8'h01;
          default: ;
        endcase
      end
    end
  end

`ifdef ROUND_KEY_STORE_EN
  logic [127:0] store [0:10];

  // entries survive an abort; only reset clears them
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i <= 10; i++) store[i] <= '0;
    end else if (rk_valid_o && (rk_idx_o <= 4'd10)) begin
      store[rk_idx_o] <= rk_i;
    end
  end

  assign rd_key_o = (rd_idx_i <= 4'd10) ? store[rd_idx_i] : '0;
`endif

endmodule
